// File: rtl/ibuff_dispatch_ctrl.sv
// Instruction-buffer dispatch controller.
// Tracks head/tail/occupancy of a circular instruction buffer, throttles fetch
// when fewer than WPORT entries are free, and presents dispatch bundles of
// DISPATCH_WIDTH consecutive entries to the backend.
// Optional feature macro: IBUFF_PARTIAL_DISPATCH_EN -- when defined, bundles
// smaller than DISPATCH_WIDTH may dispatch (any non-empty buffer is dispatchable).
module ibuff_dispatch_ctrl #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned INDEX          = 4,
    parameter int unsigned DISPATCH_WIDTH = 4,
    parameter int unsigned WPORT          = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              flush_i,
    input  logic [INDEX-1:0]                  wr_cnt_i,
    output logic [INDEX-1:0]                  wr_base_o,
    output logic                              stall_fetch_o,
    output logic [DISPATCH_WIDTH*INDEX-1:0]   rd_addr_o,
    output logic                              bundle_valid_o,
    output logic [INDEX-1:0]                  bundle_cnt_o,
    input  logic                              dispatch_ready_i,
    output logic                              overflow_err_o
);

    localparam int unsigned OW = INDEX + 1;

    logic [INDEX-1:0] head;
    logic [INDEX-1:0] tail;
    logic [OW-1:0]    occ;
    logic             overflow_err;

    logic [OW-1:0]    free_cnt;
    logic [INDEX-1:0] push_cnt;
    logic [INDEX-1:0] pop_cnt;

    // Fetch throttle depends only on registered occupancy.
    always_comb begin
        free_cnt      = OW'(DEPTH) - occ;
        stall_fetch_o = free_cnt < OW'(WPORT);
    end

`ifdef IBUFF_PARTIAL_DISPATCH_EN
    // Partial bundles: any buffered entry is dispatchable, up to DISPATCH_WIDTH.
    always_comb begin
        bundle_valid_o = (occ != '0);
        if (occ >= OW'(DISPATCH_WIDTH)) begin
            bundle_cnt_o = INDEX'(DISPATCH_WIDTH);
        end else begin
            bundle_cnt_o = occ[INDEX-1:0];
        end
    end
`else
    // Full bundles only: dispatch waits until DISPATCH_WIDTH entries exist.
    always_comb begin
        bundle_valid_o = (occ >= OW'(DISPATCH_WIDTH));
        bundle_cnt_o   = bundle_valid_o ? INDEX'(DISPATCH_WIDTH) : '0;
    end
`endif

    // Accepted push and pop amounts for this cycle.
    always_comb begin
        push_cnt = stall_fetch_o ? '0 : wr_cnt_i;
        pop_cnt  = (bundle_valid_o && dispatch_ready_i) ? bundle_cnt_o : '0;
    end

    // Read-port addresses: consecutive entries from head, wrapping modulo DEPTH.
    always_comb begin
        rd_addr_o = '0;
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
            rd_addr_o[k*INDEX +: INDEX] = head + INDEX'(k);
        end
    end

    assign wr_base_o      = tail;
    assign overflow_err_o = overflow_err;

    // Pointer and occupancy update; flush overrides any concurrent push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= head + pop_cnt;
            tail <= tail + push_cnt;
            occ  <= occ + OW'(push_cnt) - OW'(pop_cnt);
        end
    end

    // Sticky error for writes presented while fetch is stalled; flush keeps it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_err <= 1'b0;
        end else if (stall_fetch_o && (wr_cnt_i != '0)) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ibuff_dispatch_ctrl.sv
// Directed, table-driven bench for ibuff_dispatch_ctrl (default parameters).
module tb_ibuff_dispatch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        flush_i;
    logic [3:0]  wr_cnt_i;
    logic [3:0]  wr_base_o;
    logic        stall_fetch_o;
    logic [15:0] rd_addr_o;
    logic        bundle_valid_o;
    logic [3:0]  bundle_cnt_o;
    logic        dispatch_ready_i;
    logic        overflow_err_o;

    int tests_run;
    int tests_failed;

    ibuff_dispatch_ctrl #(
        .DEPTH(16),
        .INDEX(4),
        .DISPATCH_WIDTH(4),
        .WPORT(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush_i(flush_i),
        .wr_cnt_i(wr_cnt_i),
        .wr_base_o(wr_base_o),
        .stall_fetch_o(stall_fetch_o),
        .rd_addr_o(rd_addr_o),
        .bundle_valid_o(bundle_valid_o),
        .bundle_cnt_o(bundle_cnt_o),
        .dispatch_ready_i(dispatch_ready_i),
        .overflow_err_o(overflow_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic [3:0] wr;
        logic       rdy;
        int         h;
        int         t;
        int         o;
        logic       e;
    } vec_t;

    vec_t vecs[10];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_valid(input int o);
`ifdef IBUFF_PARTIAL_DISPATCH_EN
        return o > 0;
`else
        return o >= 4;
`endif
    endfunction

    function automatic int exp_cnt(input int o);
`ifdef IBUFF_PARTIAL_DISPATCH_EN
        return (o >= 4) ? 4 : o;
`else
        return (o >= 4) ? 4 : 0;
`endif
    endfunction

    // Compare every output (and occupancy) against the expected register state.
    task automatic check_state(input string tag, input int h, input int t, input int o, input logic e);
        logic [15:0] ra;
        ra = '0;
        for (int k = 0; k < 4; k++) ra[k*4 +: 4] = 4'((h + k) % 16);
        cmp({tag, ".wr_base"}, 32'(wr_base_o), 32'(t));
        cmp({tag, ".rd_addr"}, 32'(rd_addr_o), 32'(ra));
        cmp({tag, ".valid"},   32'(bundle_valid_o), 32'(exp_valid(o)));
        cmp({tag, ".cnt"},     32'(bundle_cnt_o), 32'(exp_cnt(o)));
        cmp({tag, ".stall"},   32'(stall_fetch_o), 32'((16 - o) < 8));
        cmp({tag, ".err"},     32'(overflow_err_o), 32'(e));
        cmp({tag, ".occ"},     32'(dut.occ), 32'(o));
    endtask

    task automatic step(input logic fl, input logic [3:0] wr, input logic rdy);
        @(negedge clk);
        flush_i          = fl;
        wr_cnt_i         = wr;
        dispatch_ready_i = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        reset_n          = 1'b0;
        flush_i          = 1'b0;
        wr_cnt_i         = '0;
        dispatch_ready_i = 1'b0;

        //          flush wr    rdy   h   t   o   err
        vecs[0] = '{1'b0, 4'd8, 1'b1, 0,  8,  8,  1'b0}; // write visible next cycle, no same-cycle pop
        vecs[1] = '{1'b0, 4'd0, 1'b1, 4,  8,  4,  1'b0}; // pop full bundle
        vecs[2] = '{1'b0, 4'd0, 1'b0, 4,  8,  4,  1'b0}; // idle hold
        vecs[3] = '{1'b0, 4'd5, 1'b0, 4,  13, 9,  1'b0}; // occ 9 -> stall
        vecs[4] = '{1'b0, 4'd3, 1'b0, 4,  13, 9,  1'b1}; // write while stalled ignored
        vecs[5] = '{1'b0, 4'd3, 1'b1, 8,  13, 5,  1'b1}; // stalled write ignored, pop
        vecs[6] = '{1'b0, 4'd7, 1'b1, 12, 4,  8,  1'b1}; // push wraps tail 13->4
        vecs[7] = '{1'b0, 4'd4, 1'b1, 0,  8,  8,  1'b1}; // push4 + pop4, head wraps
        vecs[8] = '{1'b1, 4'd5, 1'b1, 0,  0,  0,  1'b1}; // flush beats push/pop, err kept
        vecs[9] = '{1'b0, 4'd0, 1'b1, 0,  0,  0,  1'b1}; // empty stays empty

        #12;
        check_state("reset", 0, 0, 0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].flush, vecs[i].wr, vecs[i].rdy);
            check_state($sformatf("vec%0d", i), vecs[i].h, vecs[i].t, vecs[i].o, vecs[i].e);
        end

        // Short bundle of three entries
        step(1'b0, 4'd3, 1'b1);
        check_state("short_fill", 0, 3, 3, 1'b1);
        step(1'b0, 4'd0, 1'b1);
`ifdef IBUFF_PARTIAL_DISPATCH_EN
        check_state("short_pop", 3, 3, 0, 1'b1);
`else
        check_state("short_hold", 0, 3, 3, 1'b1);
`endif
        step(1'b1, 4'd0, 1'b0);
        check_state("flush1", 0, 0, 0, 1'b1);

`ifdef IBUFF_PARTIAL_DISPATCH_EN
        // Reach head=14, occ=6 so the read bundle wraps across 15->0
        step(1'b0, 4'd2, 1'b0); check_state("w0", 0, 2, 2, 1'b1);
        step(1'b0, 4'd0, 1'b1); check_state("w1", 2, 2, 0, 1'b1);
        step(1'b0, 4'd8, 1'b0); check_state("w2", 2, 10, 8, 1'b1);
        step(1'b0, 4'd8, 1'b1); check_state("w3", 6, 2, 12, 1'b1);
        step(1'b0, 4'd0, 1'b1); check_state("w4", 10, 2, 8, 1'b1);
        step(1'b0, 4'd0, 1'b1); check_state("w5", 14, 2, 4, 1'b1);
        step(1'b0, 4'd2, 1'b0); check_state("w6", 14, 4, 6, 1'b1);
        cmp("w6.rd_wrap", 32'(rd_addr_o), 32'h0000_10FE);
        step(1'b0, 4'd0, 1'b1); check_state("w7", 2, 4, 2, 1'b1);
`else
        // Head advancing 12 -> 0 across the buffer end
        step(1'b0, 4'd8, 1'b0); check_state("w0", 0, 8, 8, 1'b1);
        step(1'b0, 4'd8, 1'b1); check_state("w1", 4, 0, 12, 1'b1);
        step(1'b0, 4'd0, 1'b1); check_state("w2", 8, 0, 8, 1'b1);
        step(1'b0, 4'd0, 1'b1); check_state("w3", 12, 0, 4, 1'b1);
        cmp("w3.rd_top", 32'(rd_addr_o), 32'h0000_FEDC);
        step(1'b0, 4'd0, 1'b1); check_state("w4", 0, 0, 0, 1'b1);
`endif
        step(1'b1, 4'd0, 1'b0);
        check_state("flush2", 0, 0, 0, 1'b1);

        // Asynchronous reset in the middle of a cycle with buffered entries
        step(1'b0, 4'd8, 1'b0);
        check_state("pre_rst", 0, 8, 8, 1'b1);
        @(negedge clk);
        wr_cnt_i         = '0;
        dispatch_ready_i = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_state("mid_rst", 0, 0, 0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 4'd0, 1'b1);
        check_state("post_rst", 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ibuff_dispatch_ctrl.md
IBUFF_DISPATCH_CTRL -- requirements
Module: ibuff_dispatch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the instruction-buffer entry count.
REQ-002 SHALL have parameter INDEX, default 4, meaning the pointer width, log2(DEPTH).
REQ-003 SHALL have parameter DISPATCH_WIDTH, default 4, meaning the read ports per bundle.
REQ-004 SHALL have parameter WPORT, default 8, meaning the maximum writes per cycle (2x fetch width).
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port flush_i, input, 1, meaning discard all buffered instructions.
REQ-008 SHALL have port wr_cnt_i, input, INDEX, meaning the number of entries fetch writes this cycle (0..WPORT).
REQ-009 SHALL have port wr_base_o, output, INDEX: tail pointer; fetch writes slot k at wr_base_o+k mod DEPTH.
REQ-010 SHALL have port stall_fetch_o, output, 1, meaning free entries < WPORT.
REQ-011 SHALL have port rd_addr_o, output, DISPATCH_WIDTH*INDEX: slice k = head+k mod DEPTH, to RAM read port k.
REQ-012 SHALL have port bundle_valid_o, output, 1, meaning the bundle on the read ports is dispatchable.
REQ-013 SHALL have port bundle_cnt_o, output, INDEX, meaning the number of valid slots in the bundle.
REQ-014 SHALL have port dispatch_ready_i, input, 1, meaning the backend accepts the bundle this cycle.
REQ-015 SHALL have port overflow_err_o, output, 1: sticky; a write was presented while stalled.

Function
REQ-016 SHALL hold head, tail (INDEX bits, wrap modulo DEPTH) and occ (INDEX+1 bits, 0..DEPTH) registers.
REQ-017 SHALL drive stall_fetch_o = (DEPTH - occ) < WPORT, combinational from registered occ only.
REQ-018 SHALL accept a push only when stall_fetch_o=0: tail += wr_cnt_i, occ += wr_cnt_i.
REQ-019 SHALL ignore a push with wr_cnt_i>0 while stalled, and set overflow_err_o.
REQ-020 SHALL drive bundle_valid_o=1 iff occ >= DISPATCH_WIDTH, with bundle_cnt_o=DISPATCH_WIDTH (full-bundle mode).
REQ-021 SHALL pop when bundle_valid_o & dispatch_ready_i: head += bundle_cnt_o, occ -= bundle_cnt_o.
REQ-022 SHALL apply push and pop in the same cycle: occ_next = occ + push - pop.
REQ-023 SHALL make written entries dispatchable no earlier than the cycle after the write (1-cycle latency).
REQ-024 SHALL wrap pointers at DEPTH-1 -> 0, including multi-slot wrap within a push or bundle.
REQ-025 SHALL, on flush_i, set head=tail=0 and occ=0 next cycle, overriding a simultaneous push/pop; overflow_err_o is unaffected.
REQ-026 SHALL keep pointers and occ unchanged when dispatch_ready_i=0 and no push occurs.

Reset
REQ-027 SHALL on reset_n=0 asynchronously clear head, tail, occ and overflow_err_o.
REQ-028 SHALL during reset drive: stall_fetch_o=0 (DEPTH>=WPORT), bundle_valid_o=0, bundle_cnt_o=0, wr_base_o=0, rd_addr_o slice k=k.
REQ-029 SHALL drop partially buffered state on reset mid-operation, with no pending pop retained.

Configuration
REQ-030 SHALL support macro IBUFF_PARTIAL_DISPATCH_EN.
REQ-031 SHALL, when IBUFF_PARTIAL_DISPATCH_EN is defined, drive bundle_valid_o=(occ>0), bundle_cnt_o=min(occ, DISPATCH_WIDTH), and pop that count.
REQ-032 SHALL, when IBUFF_PARTIAL_DISPATCH_EN is undefined, behave per REQ-020 (full bundles only).

Verification
REQ-033 SHALL cover: reset, then wr_cnt_i=8 for one cycle, ready=1 -> next cycle occ=8, bundle_valid_o=1, rd_addr_o={3,2,1,0}; following cycle head=4.
REQ-034 SHALL cover: fill to occ=9 with ready=0 -> stall_fetch_o=1; wr_cnt_i=3 presented -> occ stays 9, overflow_err_o=1.
REQ-035 SHALL cover: head=14, occ=6, ready=1 -> rd_addr_o={1,0,15,14}; next head=2, occ=2.
REQ-036 SHALL cover: occ=8, push 4 and pop 4 in the same cycle -> occ=8, head+4, tail+4.
REQ-037 SHALL cover: flush_i=1 with wr_cnt_i=5 and ready=1 -> next cycle occ=0, head=tail=0, bundle_valid_o=0.
REQ-038 SHALL cover: occ=3 -> bundle_valid_o=0 without the macro; with IBUFF_PARTIAL_DISPATCH_EN, bundle_cnt_o=3 and occ->0 after ready.
